// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller.
//   state_e        : controller FSM states
//   REQ_IF/REQ_LS  : requester IDs, also the bit positions in the arbiter request vector
//   MDR_SRC_*      : encodings of the external MDR input mux select
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StAccess,
    StCapture,
    StDone
  } state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  localparam logic MDR_SRC_MEM   = 1'b0;
  localparam logic MDR_SRC_STORE = 1'b1;

endpackage

// File: rtl/mem_access_controller_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, reset  : clock, asynchronous active-high reset
//   req[1:0]    : request vector, bit REQ_IF = fetch, bit REQ_LS = load/store
//   update      : commit the current grant as last_grant
//   grant_id    : winning requester (valid when grant_valid)
//   grant_valid : at least one request pending
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant_id,
  output logic       grant_valid
);

  logic last_grant_q;

  // Reset to LS so the first tie goes to IF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= REQ_LS;
    end else if (update && grant_valid) begin
      last_grant_q <= grant_id;
    end
  end

  always_comb begin
    grant_valid = |req;
    case (req)
      2'b01:   grant_id = REQ_IF;
      2'b10:   grant_id = REQ_LS;
      2'b11:   grant_id = ~last_grant_q;
      default: grant_id = REQ_IF;
    endcase
  end

endmodule

// File: rtl/mem_access_controller.sv
// Memory access controller: sequences CPU memory transactions through MAR/MDR,
// arbitrating between instruction fetch (IF) and load/store (LS).
//   clk, reset          : clock, asynchronous active-high reset
//   if_req/if_addr      : fetch request (held until if_done) and address
//   if_done             : one-cycle completion pulse to IF
//   ls_req/ls_we/ls_addr: load/store request (held until ls_done), store flag, address
//   ls_done             : one-cycle completion pulse to LS
//   mar_out             : MAR contents, drives the memory address bus
//   mdr_we/mdr_src      : MDR write enable and input select (mux is external)
//   mem_req/mem_we      : memory request and write strobe
//   mem_ready           : memory completion, only looked at in ACCESS
//   bus_err             : asserted with the done pulse when the access timed out
//   busy                : high whenever not IDLE
module mem_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  output logic                  ls_done,
  output logic [ADDR_WIDTH-1:0] mar_out,
  output logic                  mdr_we,
  output logic                  mdr_src,
  output logic                  mem_req,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic                  bus_err,
  output logic                  busy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("DATA_WIDTH must be at least 1");
  end

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  gnt_id_q, gnt_id_d;
  logic                  op_we_q, op_we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] mar_q, mar_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  arb_update;
  logic                  arb_grant_id;
  logic                  arb_grant_valid;
  logic [1:0]            arb_req;

  assign arb_req = {ls_req, if_req};

  rr_arb2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (arb_req),
    .update      (arb_update),
    .grant_id    (arb_grant_id),
    .grant_valid (arb_grant_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      gnt_id_q <= REQ_IF;
      op_we_q  <= 1'b0;
      addr_q   <= '0;
      mar_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      op_we_q  <= op_we_d;
      addr_q   <= addr_d;
      mar_q    <= mar_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    op_we_d    = op_we_q;
    addr_d     = addr_q;
    mar_d      = mar_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    arb_update = 1'b0;
    if_done    = 1'b0;
    ls_done    = 1'b0;
    mdr_we     = 1'b0;
    mdr_src    = MDR_SRC_MEM;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    bus_err    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_grant_valid) begin
          // Latch everything about the winner so later input changes are ignored.
          gnt_id_d   = arb_grant_id;
          op_we_d    = (arb_grant_id == REQ_LS) ? ls_we : 1'b0;
          addr_d     = (arb_grant_id == REQ_LS) ? ls_addr : if_addr;
          arb_update = 1'b1;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        mar_d = addr_q;
        cnt_d = '0;
        if (op_we_q) begin
          mdr_we  = 1'b1;
          mdr_src = MDR_SRC_STORE;
        end
        state_d = StAccess;
      end
      StAccess: begin
        mem_req = 1'b1;
        mem_we  = op_we_q;
        // A ready in the final allowed cycle still wins over the timeout.
        if (mem_ready) begin
          state_d = op_we_q ? StDone : StCapture;
        end else if (cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StCapture: begin
        mdr_we  = 1'b1;
        mdr_src = MDR_SRC_MEM;
        state_d = StDone;
      end
      StDone: begin
        if_done = (gnt_id_q == REQ_IF);
        ls_done = (gnt_id_q == REQ_LS);
        bus_err = err_q;
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mar_out = mar_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mem_access_controller.sv
module tb_mem_access_controller;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, ls_req, ls_we, mem_ready;
  logic [31:0] if_addr, ls_addr;
  logic        if_done, ls_done, mdr_we, mdr_src, mem_req, mem_we, bus_err, busy;
  logic [31:0] mar_out;

  int checks = 0;
  int errors = 0;
  bit model_last;  // 0 = IF last granted, 1 = LS last granted

  typedef struct {
    bit          ls_won;
    int          lat;
    bit          err;
    int          mreq;
    int          mwe;
    logic [31:0] mar;
    int          st;
    int          cap;
    int          dones;
  } res_t;

  typedef struct {
    bit          ir;
    bit          lr;
    bit          we;
    logic [31:0] ia;
    logic [31:0] la;
    int          waits;
    bit          hold;
    res_t        exp;
  } vec_t;

  mem_access_controller #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_done   (ls_done),
    .mar_out   (mar_out),
    .mdr_we    (mdr_we),
    .mdr_src   (mdr_src),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .bus_err   (bus_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: who wins, how long, what side effects.
  function automatic res_t model(input bit ir, input bit lr, input bit we,
                                 input logic [31:0] ia, input logic [31:0] la, input int waits);
    res_t r;
    bit   ls, store, to;
    int   acc;
    ls         = (ir && lr) ? !model_last : lr;
    model_last = ls;
    store      = ls && we;
    to         = (waits + 1) > TO;
    acc        = to ? TO : waits + 1;
    r.ls_won   = ls;
    r.err      = to;
    r.mreq     = acc;
    r.mwe      = store ? acc : 0;
    r.mar      = ls ? la : ia;
    r.st       = store ? 1 : 0;
    r.cap      = (!store && !to) ? 1 : 0;
    r.lat      = 1 + acc + r.cap + 1;
    r.dones    = 1;
    return r;
  endfunction

  // Runs one transaction from an IDLE cycle; memory answers after `waits` wait states.
  task automatic run_txn(input bit ir, input bit lr, input bit we, input logic [31:0] ia,
                         input logic [31:0] la, input int waits, input bit hold,
                         input bit drop_at_load, output res_t o);
    int acc;
    bit seen;
    acc = 0;
    seen = 0;
    o = '{ls_won: 0, lat: -1, err: 0, mreq: 0, mwe: 0, mar: 32'h0, st: 0, cap: 0, dones: 0};
    @(negedge clk);
    chk("idle before txn", busy, 0);
    if_req = ir; ls_req = lr; ls_we = we; if_addr = ia; ls_addr = la;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Inputs after the grant must be ignored.
        if_addr = ~ia; ls_addr = ~la; ls_we = ~we;
        if (drop_at_load) begin if_req = 0; ls_req = 0; end
      end
      if (mem_req) begin
        acc++;
        o.mreq++;
        if (mem_we) o.mwe++;
        if (acc == 1) o.mar = mar_out;
      end
      mem_ready = mem_req && (acc - 1 == waits);
      if (mdr_we) begin
        if (mdr_src) o.st++;
        else o.cap++;
      end
      if (if_done || ls_done) begin
        o.dones += int'(if_done) + int'(ls_done);
        o.ls_won = ls_done;
        o.err    = bus_err;
        o.lat    = k;
        seen     = 1;
      end
    end
    mem_ready = 0;
    if (!hold) begin if_req = 0; ls_req = 0; end
  endtask

  task automatic cmp(input string tag, input res_t o, input res_t e);
    chk({tag, " winner"}, o.ls_won, e.ls_won);
    chk({tag, " latency"}, o.lat, e.lat);
    chk({tag, " bus_err"}, o.err, e.err);
    chk({tag, " mem_req cycles"}, o.mreq, e.mreq);
    chk({tag, " mem_we cycles"}, o.mwe, e.mwe);
    chk({tag, " mar"}, o.mar, e.mar);
    chk({tag, " mdr store writes"}, o.st, e.st);
    chk({tag, " mdr capture writes"}, o.cap, e.cap);
    chk({tag, " done pulses"}, o.dones, e.dones);
  endtask

  initial begin
    vec_t vecs[11];
    res_t o, e;
    int   acc;
    bit   dn;

    vecs[0]  = '{1, 0, 0, 32'h100, 32'h0,    0, 0, '{0, 4, 0, 1, 0, 32'h100, 0, 1, 1}};
    vecs[1]  = '{0, 1, 1, 32'h0,   32'h2000, 3, 0, '{1, 6, 0, 4, 4, 32'h2000, 1, 0, 1}};
    vecs[2]  = '{1, 1, 0, 32'h10,  32'h20,   0, 1, '{0, 4, 0, 1, 0, 32'h10, 0, 1, 1}};
    vecs[3]  = '{1, 1, 0, 32'h10,  32'h20,   0, 1, '{1, 4, 0, 1, 0, 32'h20, 0, 1, 1}};
    vecs[4]  = '{1, 1, 0, 32'h10,  32'h20,   0, 1, '{0, 4, 0, 1, 0, 32'h10, 0, 1, 1}};
    vecs[5]  = '{1, 1, 0, 32'h10,  32'h20,   0, 0, '{1, 4, 0, 1, 0, 32'h20, 0, 1, 1}};
    vecs[6]  = '{1, 0, 0, 32'h500, 32'h0,   99, 0, '{0, 17, 1, 15, 0, 32'h500, 0, 0, 1}};
    vecs[7]  = '{0, 1, 0, 32'h0,   32'h600,  2, 0, '{1, 6, 0, 3, 0, 32'h600, 0, 1, 1}};
    vecs[8]  = '{0, 1, 1, 32'h0,   32'h700, 14, 0, '{1, 17, 0, 15, 15, 32'h700, 1, 0, 1}};
    vecs[9]  = '{0, 1, 1, 32'h0,   32'h800, 15, 0, '{1, 17, 1, 15, 15, 32'h800, 1, 0, 1}};
    vecs[10] = '{1, 1, 1, 32'h900, 32'ha00,  0, 0, '{0, 4, 0, 1, 0, 32'h900, 0, 1, 1}};

    reset = 1; if_req = 0; ls_req = 0; ls_we = 0; mem_ready = 0;
    if_addr = 0; ls_addr = 0;
    model_last = 1;
    repeat (2) @(negedge clk);
    chk("reset outputs", {if_done, ls_done, mdr_we, mdr_src, mem_req, mem_we, bus_err, busy}, 0);
    chk("reset mar", mar_out, 0);
    reset = 0;

    for (int i = 0; i < 11; i++) begin
      e = model(vecs[i].ir, vecs[i].lr, vecs[i].we, vecs[i].ia, vecs[i].la, vecs[i].waits);
      run_txn(vecs[i].ir, vecs[i].lr, vecs[i].we, vecs[i].ia, vecs[i].la, vecs[i].waits,
              vecs[i].hold, 0, o);
      cmp($sformatf("vec%0d", i), o, vecs[i].exp);
    end

    // Spurious mem_ready while idle, then a fetch whose request drops in LOAD.
    @(negedge clk);
    mem_ready = 1;
    @(negedge clk);
    chk("spurious ready busy", busy, 0);
    chk("spurious ready mem_req", mem_req, 0);
    mem_ready = 0;
    @(negedge clk);
    chk("spurious ready busy later", busy, 0);
    e = model(1, 0, 0, 32'h400, 32'h0, 1);
    run_txn(1, 0, 0, 32'h400, 32'h0, 1, 0, 1, o);
    cmp("drop in load", o, e);

    // Reset during the 2nd wait cycle of a read.
    @(negedge clk);
    if_req = 1; if_addr = 32'h300; acc = 0;
    for (int k = 0; k < 10 && acc < 2; k++) begin
      @(negedge clk);
      if (mem_req) acc++;
    end
    chk("reached 2nd wait cycle", acc, 2);
    chk("pre-reset mar", mar_out, 32'h300);
    #1 reset = 1;
    #1;
    chk("async reset mem_req", mem_req, 0);
    chk("async reset busy", busy, 0);
    chk("async reset mar", mar_out, 0);
    if_req = 0;
    dn = 0;
    repeat (2) begin
      @(negedge clk);
      dn |= if_done | ls_done | mdr_we;
    end
    chk("no done or mdr write across reset", dn, 0);
    reset = 0;
    model_last = 1;
    e = model(1, 1, 1, 32'h111, 32'h222, 0);
    run_txn(1, 1, 1, 32'h111, 32'h222, 0, 0, 0, o);
    cmp("tie after reset", o, e);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      bit          ir, lr, we;
      logic [31:0] ia, la;
      int          w;
      ir = 1'($urandom_range(0, 1));
      lr = ir ? 1'($urandom_range(0, 1)) : 1'b1;
      we = 1'($urandom_range(0, 1));
      ia = $urandom;
      la = $urandom;
      w  = $urandom_range(0, 17);
      e = model(ir, lr, we, ia, la, w);
      run_txn(ir, lr, we, ia, la, w, 0, 0, o);
      cmp($sformatf("rand%0d", i), o, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
